hamming_dec_engine: RTL and testbench

Hardware SECDED (16,11) decode engine that replaces the software program-2 pass. It walks the data memory, reads fifteen 16-bit Hamming-coded words stored as byte pairs, and corrects single-bit errors. It writes each 11-bit message plus a 2-bit status flag back into the low region of the same memory, then raises `done` to the controlling bench or processor.

---
 rtl/hamming_pkg.sv | 50 +++++
 rtl/secded_16_11_dec.sv | 32 +++
 rtl/hamming_dec_engine.sv | 139 +++++++++++++
 tb/tb_hamming_dec_engine.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types, constants and SECDED helper functions for the (16,11) decode engine.
package hamming_pkg;

  // Engine sequencing states.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_DEC   = 3'd3,
    S_WR_LO = 3'd4,
    S_WR_HI = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  // Status flag written into bits 15:14 of each result word.
  localparam logic [1:0] FLG_OK  = 2'b00;
  localparam logic [1:0] FLG_SGL = 2'b01;
  localparam logic [1:0] FLG_DBL = 2'b10;

  // Data-bit positions inside the encoded word: d1 at 3, d4..d2 at 7..5, d11..d5 at 15..9.
  localparam int unsigned D1_POS    = 3;
  localparam int unsigned D2_POS    = 5;
  localparam int unsigned D5_POS    = 9;
  localparam logic [15:0] DATA_MASK = 16'hFEE8;

  // Gather the eleven message bits, d11 in the MSB.
  function automatic logic [10:0] extract_data(input logic [15:0] w);
    return {w[15:9], w[7:5], w[3]};
  endfunction

  // XOR of the indices of all set bits in positions 1..15.
  function automatic logic [3:0] calc_syndrome(input logic [15:0] w);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (w[i]) begin
        s = s ^ 4'(i);
      end else begin
        s = s;
      end
    end
    return s;
  endfunction

  // Overall parity across all sixteen bits.
  function automatic logic calc_parity(input logic [15:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/secded_16_11_dec.sv
// Combinational SECDED (16,11) decoder: corrects single errors, flags double errors.
module secded_16_11_dec
  import hamming_pkg::*;
(
  input  logic [15:0] code_i,
  output logic [11:1] data_o,
  output logic [1:0]  flag_o
);

  logic [3:0]  syn_s;
  logic        par_s;
  logic [15:0] corr_s;

  // Classify the word and flip the faulty bit when exactly one error is detected.
  always_comb begin
    syn_s  = calc_syndrome(code_i);
    par_s  = calc_parity(code_i);
    corr_s = code_i;
    flag_o = FLG_OK;
    if (par_s) begin
      // Syndrome 0 with odd parity means p0 itself flipped; shifting by 0 fixes it harmlessly.
      flag_o = FLG_SGL;
      corr_s = code_i ^ (16'h0001 << syn_s);
    end else if (syn_s != 4'd0) begin
      flag_o = FLG_DBL;
    end else begin
      flag_o = FLG_OK;
    end
    data_o = extract_data(corr_s);
  end

endmodule

// File: rtl/hamming_dec_engine.sv
// Memory-walking SECDED decode engine: reads N_MSG coded words, writes flagged messages back.
module hamming_dec_engine
  import hamming_pkg::*;
#(
  parameter int unsigned SRC_BASE = 30,
  parameter int unsigned DST_BASE = 0,
  parameter int unsigned N_MSG    = 15,
  parameter int unsigned AW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic [7:0]    mem_wdata,
  output logic          mem_we
);

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    hi_q, hi_d;
  logic [15:0]   res_q, res_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          done_q, done_d;
  logic [AW-1:0] off_s;
  logic [11:1]   dec_data_s;
  logic [1:0]    dec_flag_s;

  secded_16_11_dec u_dec (
    .code_i ({hi_q, lo_q}),
    .data_o (dec_data_s),
    .flag_o (dec_flag_s)
  );

  // Next-state, index and datapath capture for the read/decode/write sequence.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RD_LO;
          idx_d   = 4'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_RD_LO: begin
        lo_d    = mem_rdata;
        state_d = S_RD_HI;
      end
      S_RD_HI: begin
        hi_d    = mem_rdata;
        state_d = S_DEC;
      end
      S_DEC: begin
        res_d   = {dec_flag_s, 3'b000, dec_data_s};
        state_d = S_WR_LO;
      end
      S_WR_LO: begin
        state_d = S_WR_HI;
      end
      S_WR_HI: begin
        if (idx_q == 4'(N_MSG - 1)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_RD_LO;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory-port and done values for the upcoming state, so every output leaves a flop.
  always_comb begin
    off_s   = AW'({idx_d, 1'b0});
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      S_RD_LO: addr_d = AW'(SRC_BASE) + off_s;
      S_RD_HI: addr_d = AW'(SRC_BASE) + off_s + AW'(1'b1);
      S_WR_LO: begin
        addr_d  = AW'(DST_BASE) + off_s;
        wdata_d = res_d[7:0];
        we_d    = 1'b1;
      end
      S_WR_HI: begin
        addr_d  = AW'(DST_BASE) + off_s + AW'(1'b1);
        wdata_d = res_d[15:8];
        we_d    = 1'b1;
      end
      S_DONE:  done_d = 1'b1;
      default: addr_d = addr_q;
    endcase
  end

  // State and output registers; reset drops the write strobe immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      lo_q    <= 8'h00;
      hi_q    <= 8'h00;
      res_q   <= 16'h0000;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      res_q   <= res_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign done      = done_q;

endmodule

// File: tb/tb_hamming_dec_engine.sv
// Directed bench for hamming_dec_engine with a byte-array memory model.
module tb_hamming_dec_engine;

  logic       clk;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_we;

  logic [7:0] mem [256];
  logic       tb_we;
  logic [7:0] tb_addr;
  logic [7:0] tb_wdata;
  int         wr_cnt;
  int         bad_wr;

  int errors;
  int checks;

  logic [15:0] src    [15];
  logic [7:0]  exp_lo [15];
  logic [7:0]  exp_hi [15];

  hamming_dec_engine #(
    .SRC_BASE (30),
    .DST_BASE (0),
    .N_MSG    (15),
    .AW       (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  // Memory write port (DUT has priority) plus write-range monitor.
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      if (mem_addr > 8'd29) bad_wr <= bad_wr + 1;
    end else if (tb_we) begin
      mem[tb_addr] <= tb_wdata;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_addr = a; tb_wdata = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // Reference encoder: place data, then parity bits so the syndrome and overall parity are zero.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] w;
    logic [3:0]  s;
    w = 16'h0000;
    w[3] = d[0];
    w[7:5] = d[3:1];
    w[15:9] = d[10:4];
    s = 4'd0;
    for (int k = 1; k < 16; k++) if (w[k]) s = s ^ 4'(k);
    w[1] = s[0]; w[2] = s[1]; w[4] = s[2]; w[8] = s[3];
    w[0] = ^w[15:1];
    return w;
  endfunction

  task automatic make_random(input int first);
    logic [10:0] d;
    logic [15:0] w;
    logic [15:0] r;
    int kind, p1, p2;
    for (int i = first; i < 15; i++) begin
      d = 11'($urandom_range(0, 2047));
      kind = $urandom_range(0, 2);
      w = encode(d);
      p1 = $urandom_range(0, 15);
      p2 = (p1 + 1 + $urandom_range(0, 14)) % 16;
      if (kind >= 1) w[p1] = ~w[p1];
      if (kind == 2) w[p2] = ~w[p2];
      if (kind == 0)      r = {2'b00, 3'b000, d};
      else if (kind == 1) r = {2'b01, 3'b000, d};
      else                r = {2'b10, 3'b000, w[15:9], w[7:5], w[3]};
      src[i] = w; exp_lo[i] = r[7:0]; exp_hi[i] = r[15:8];
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 15; i++) begin
      poke(8'(30 + 2 * i), src[i][7:0]);
      poke(8'(31 + 2 * i), src[i][15:8]);
    end
    for (int j = 0; j < 30; j++) poke(8'(j), 8'hAA);
  endtask

  // Pulse start; returns at the falling edge inside cycle 1 of the run.
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Walk cycles 1..76 of a run checking strobe and done timing; optional back-to-back restart.
  task automatic run_timed(input bit hold_end);
    for (int cyc = 1; cyc <= 76; cyc++) begin
      if (cyc == 3) chk("we_cycle3", {15'd0, mem_we}, 16'd0);
      if (cyc == 4) chk("we_cycle4", {15'd0, mem_we}, 16'd1);
      if (cyc == 10) start = 1'b1;
      if (cyc == 11) start = 1'b0;
      if (cyc == 75) begin
        chk("done_cycle75", {15'd0, done}, 16'd0);
        if (hold_end) start = 1'b1;
      end
      if (cyc == 76) chk("done_cycle76", {15'd0, done}, 16'd1);
      else @(negedge clk);
    end
    if (hold_end) begin
      @(negedge clk);
      start = 1'b0;
      chk("done_drop_rerun", {15'd0, done}, 16'd0);
    end
  endtask

  task automatic check_results(input string tag);
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("%s_lo%0d", tag, i), {8'h00, mem[2 * i]},     {8'h00, exp_lo[i]});
      chk($sformatf("%s_hi%0d", tag, i), {8'h00, mem[2 * i + 1]}, {8'h00, exp_hi[i]});
    end
  endtask

  initial begin
    int wr_snap;
    errors = 0; checks = 0; wr_cnt = 0; bad_wr = 0;
    reset = 1'b0; start = 1'b0;
    tb_we = 1'b0; tb_addr = 8'h00; tb_wdata = 8'h00;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_done",  {15'd0, done},   16'd0);
    chk("rst_we",    {15'd0, mem_we}, 16'd0);
    chk("rst_addr",  {8'h00, mem_addr},  16'd0);
    chk("rst_wdata", {8'h00, mem_wdata}, 16'd0);
    reset = 1'b1;

    // Run A: four directed words then random ones, restarted back-to-back by a held start.
    src[0] = 16'hFFFF; exp_lo[0] = 8'hFF; exp_hi[0] = 8'h07;
    src[1] = 16'hFFFE; exp_lo[1] = 8'hFF; exp_hi[1] = 8'h47;
    src[2] = 16'h2000; exp_lo[2] = 8'h00; exp_hi[2] = 8'h40;
    src[3] = 16'h0003; exp_lo[3] = 8'h00; exp_hi[3] = 8'h80;
    make_random(4);
    preload();
    wr_snap = wr_cnt;
    kick();
    run_timed(1'b1);
    check_results("runA");
    run_timed(1'b0);
    check_results("runA2");
    chk("runA_wr_count", 16'(wr_cnt - wr_snap), 16'd60);

    // Run B: fifteen random words.
    make_random(0);
    preload();
    wr_snap = wr_cnt;
    kick();
    run_timed(1'b0);
    check_results("runB");
    chk("runB_wr_count", 16'(wr_cnt - wr_snap), 16'd30);

    // Run C: reset asserted at cycle 23, then a clean rerun.
    for (int j = 0; j < 30; j++) poke(8'(j), 8'hAA);
    kick();
    for (int c = 1; c < 23; c++) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_we",   {15'd0, mem_we},  16'd0);
    chk("midrst_done", {15'd0, done},    16'd0);
    chk("midrst_addr", {8'h00, mem_addr}, 16'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("kept_lo%0d", i), {8'h00, mem[2 * i]},     {8'h00, exp_lo[i]});
      chk($sformatf("kept_hi%0d", i), {8'h00, mem[2 * i + 1]}, {8'h00, exp_hi[i]});
    end
    chk("untouched_8", {8'h00, mem[8]}, 16'h00AA);
    wr_snap = wr_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_writes", 16'(wr_cnt - wr_snap), 16'd0);
    chk("idle_done",      {15'd0, done}, 16'd0);
    kick();
    run_timed(1'b0);
    check_results("runC");
    chk("wr_range", 16'(bad_wr), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
